// File: rtl/cpu_tx_bridge.sv
// CPU-to-UART bridge: divided CPU clock, falling-edge byte capture into a FIFO,
// and an 8N1 serialiser that drains the FIFO with back-to-back frames.
module cpu_tx_bridge #(
    parameter int unsigned CLOCKS_PER_BAUD = 2604,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned DIV_BIT         = 11
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_tx_n,
    input  logic [7:0]               i_data,
    output logic                     o_cpu_clk,
    output logic                     o_uart_tx,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL  = (AW+1)'(DEPTH);
    localparam logic [23:0] BAUD_RELOAD = 24'(CLOCKS_PER_BAUD - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [DIV_BIT:0] div_count;
    logic             prev_tx_n;
    logic [7:0]       mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      level;
    logic [23:0]      baud_count;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    state_t           state;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic             accept;

    assign push   = !i_tx_n && prev_tx_n;
    assign level  = wr_ptr - rd_ptr;
    assign empty  = (level == '0);
    assign full   = (level == FULL_LEVEL);
    // The serialiser takes a byte when idle or exactly at the end of a stop bit.
    assign pop    = !empty && ((state == IDLE) || ((state == STOP) && (baud_count == '0)));
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign accept = push && (!full || pop);

    assign o_cpu_clk = div_count[DIV_BIT];
    assign o_level   = level;
    assign o_busy    = (state != IDLE) || !empty;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div_count <= '0;
            prev_tx_n <= 1'b1;
        end else begin
            div_count <= div_count + 1'b1;
            prev_tx_n <= i_tx_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem[wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !accept) begin
                o_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            o_uart_tx  <= 1'b1;
            baud_count <= '0;
            bit_idx    <= '0;
            shift      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_uart_tx <= 1'b1;
                    if (pop) begin
                        shift      <= mem[rd_ptr[AW-1:0]];
                        baud_count <= BAUD_RELOAD;
                        o_uart_tx  <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (baud_count == '0) begin
                        baud_count <= BAUD_RELOAD;
                        bit_idx    <= '0;
                        o_uart_tx  <= shift[0];
                        state      <= DATA;
                    end else begin
                        baud_count <= baud_count - 24'd1;
                    end
                end
                DATA: begin
                    if (baud_count == '0) begin
                        baud_count <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
                            o_uart_tx <= 1'b1;
                            state     <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift     <= {1'b0, shift[7:1]};
                            o_uart_tx <= shift[1];
                        end
                    end else begin
                        baud_count <= baud_count - 24'd1;
                    end
                end
                STOP: begin
                    if (baud_count == '0) begin
                        if (pop) begin
                            shift      <= mem[rd_ptr[AW-1:0]];
                            baud_count <= BAUD_RELOAD;
                            o_uart_tx  <= 1'b0;
                            state      <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_count <= baud_count - 24'd1;
                    end
                end
                default: begin
                    o_uart_tx <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_tx_bridge.sv
// Randomised bench for cpu_tx_bridge, checked every cycle against a queue and
// frame-schedule reference model of the bridge.
module tb_cpu_tx_bridge;

    localparam int CPB     = 4;
    localparam int DEPTH   = 4;
    localparam int DIV_BIT = 2;
    localparam int FRAME   = 10 * CPB;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tx_n = 1'b1;
    logic [7:0]    data = 8'h00;
    logic          cpu_clk;
    logic          uart_tx;
    logic          busy;
    logic [LW-1:0] level;
    logic          ovf;

    int check_count = 0;
    int fail_count  = 0;

    // Reference model: byte queue plus the start edge of the frame on the line.
    logic [7:0] m_q[$];
    logic [7:0] m_byte;
    logic       m_active;
    logic       m_ovf;
    logic       m_prev_tx;
    int         m_edge;
    int         m_start;

    cpu_tx_bridge #(
        .CLOCKS_PER_BAUD(CPB),
        .DEPTH(DEPTH),
        .DIV_BIT(DIV_BIT)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_tx_n(tx_n),
        .i_data(data),
        .o_cpu_clk(cpu_clk),
        .o_uart_tx(uart_tx),
        .o_busy(busy),
        .o_level(level),
        .o_overflow(ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        m_q.delete();
        m_byte    = 8'h00;
        m_active  = 1'b0;
        m_ovf     = 1'b0;
        m_prev_tx = 1'b1;
        m_edge    = 0;
        m_start   = 0;
    endtask

    task automatic modelStep();
        m_edge++;
        if (m_active && (m_edge == m_start + FRAME)) begin
            m_active = 1'b0;
        end
        if (!m_active && (m_q.size() != 0)) begin
            m_byte   = m_q.pop_front();
            m_start  = m_edge;
            m_active = 1'b1;
        end
        if (!tx_n && m_prev_tx) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(data);
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_prev_tx = tx_n;
    endtask

    function automatic logic expTx();
        int k;
        if (!m_active) return 1'b1;
        k = (m_edge - m_start) / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    initial begin
        resetModel();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) resetModel();
            else modelStep();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("uartTx", 32'(uart_tx), 32'(expTx()));
            checkOutput("level", 32'(level), 32'(m_q.size()));
            checkOutput("busy", 32'(busy), 32'(m_active || (m_q.size() != 0)));
            checkOutput("overflow", 32'(ovf), 32'(m_ovf));
            checkOutput("cpuClk", 32'(cpu_clk), 32'((m_edge >> DIV_BIT) & 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [7:0] value, input int low_cycles, input int high_cycles);
        data = value;
        tx_n = 1'b0;
        repeat (low_cycles) tick();
        tx_n = 1'b1;
        repeat (high_cycles) begin
            data = 8'($urandom);
            tick();
        end
    endtask

    task automatic doReset();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rstTx", 32'(uart_tx), 1);
        checkOutput("rstLevel", 32'(level), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstOverflow", 32'(ovf), 0);
        checkOutput("rstCpuClk", 32'(cpu_clk), 0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic waitIdle(input int max_cycles);
        int n = 0;
        while ((m_active || (m_q.size() != 0)) && (n < max_cycles)) begin
            tick();
            n++;
        end
        checkOutput("drainBusy", 32'(busy), 0);
        checkOutput("drainLevel", 32'(level), 0);
    endtask

    task automatic waitEdge(input int target, input int max_cycles);
        int n = 0;
        while ((m_edge < target) && (n < max_cycles)) begin
            tick();
            n++;
        end
        checkOutput("edgeReached", 32'(m_edge), 32'(target));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout: got time %0t, expected completion earlier", $time);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #21 rst_n = 1'b1;
        tick();

        // Single byte: long low pulse gives one frame, line falls two edges after detect.
        data = 8'hA5;
        tx_n = 1'b0;
        tick();
        checkOutput("singleLevelAfterDetect", 32'(level), 1);
        checkOutput("singleTxStillIdle", 32'(uart_tx), 1);
        tick();
        checkOutput("singleTxStartBit", 32'(uart_tx), 0);
        repeat (18) tick();
        tx_n = 1'b1;
        waitIdle(200);

        // Burst of three on consecutive falling edges.
        applyStimulus(8'h01, 1, 1);
        applyStimulus(8'h02, 1, 1);
        applyStimulus(8'h03, 1, 1);
        checkOutput("burstPeakLevel", 32'(level), 2);
        waitIdle(300);

        // Overflow: six pushes during the first frame.
        for (int i = 0; i < 6; i++) applyStimulus(8'($urandom), 1, 1);
        checkOutput("ovfLevel", 32'(level), 4);
        checkOutput("ovfFlag", 32'(ovf), 1);
        waitIdle(400);

        // Push coinciding with the stop-to-start pop while full.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(8'($urandom), 1, 1);
        waitEdge(m_start + FRAME - 1, 100);
        data = 8'($urandom);
        tx_n = 1'b0;
        tick();
        checkOutput("fullPushPopLevel", 32'(level), 4);
        checkOutput("fullPushPopOvf", 32'(ovf), 0);
        tx_n = 1'b1;
        waitIdle(400);

        // Reset in the middle of data bit 3 with bytes still queued.
        for (int i = 0; i < 3; i++) applyStimulus(8'($urandom), 1, 1);
        waitEdge(m_start + 4 * CPB + 1, 100);
        doReset();
        applyStimulus(8'h3C, 2, 2);
        waitIdle(200);

        // Low level held across three CPU clock periods.
        applyStimulus(8'($urandom), 3 * (2 << DIV_BIT), 4);
        waitIdle(200);

        // Random traffic with mixed spacing, including overflow bursts.
        repeat (25) begin
            applyStimulus(8'($urandom), int'($urandom_range(1, 5)), int'($urandom_range(1, 30)));
        end
        waitIdle(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/cpu_tx_bridge.md
# cpu_tx_bridge

Parametrised successor to the single-byte CPU-to-UART link on the board top level. It generates the slow CPU clock, turns each falling edge of the CPU's active-low TX signal into exactly one byte capture, and buffers bytes in a FIFO. The buffered bytes drain through an internal 8N1 serialiser. Bytes written while the line is busy are queued instead of lost, and the block flags overflow when the queue is full.

## Interface
- CLOCKS_PER_BAUD, 2604: i_clk cycles per UART bit (24-bit value, minimum 2).
- DEPTH, 16: FIFO depth in bytes; must be a power of two, at least 2.
- DIV_BIT, 11: counter bit tapped to form o_cpu_clk.
- i_clk  input  1  system clock (25 MHz on the board).
- i_reset_n  input  1  asynchronous active-low reset.
- i_tx_n  input  1  CPU transmit request, active low, synchronous to i_clk (derived from o_cpu_clk).
- i_data  input  8  byte to send, valid whenever i_tx_n is low.
- o_cpu_clk  output  1  divided clock for the CPU, counter[DIV_BIT].
- o_uart_tx  output  1  serial line, idle high.
- o_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- o_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- o_overflow  output  1  sticky flag: a byte was dropped.

## Operation
- Divider: a free-running counter, wide enough to hold DIV_BIT+1 bits, increments every i_clk and wraps naturally; o_cpu_clk = counter[DIV_BIT].
- Edge detect: a register prev_tx_n resets to 1. A push request is raised on a clock edge where i_tx_n==0 and prev_tx_n==1. A low level held for any length of time gives exactly one request.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - Push writes i_data at the write pointer.
  - Full when level==DEPTH; empty when level==0.
  - Push while full and no pop in the same cycle: the byte is dropped, o_overflow is set, and the pointers are unchanged.
  - Push and pop in the same cycle: both happen, and the level is unchanged. This applies when full as well, so the byte is accepted.
  - Pop from an empty FIFO never occurs.
- Serialiser FSM, with states IDLE, START, DATA, STOP:
  - IDLE: o_uart_tx=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: drive 0 for CLOCKS_PER_BAUD cycles, then go to DATA.
  - DATA: drive shift[0] for CLOCKS_PER_BAUD cycles per bit, LSB first, 8 bits; a 3-bit bit counter tracks the position. Then go to STOP.
  - STOP: drive 1 for CLOCKS_PER_BAUD cycles. If the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
  - The baud counter reloads to CLOCKS_PER_BAUD-1 on every bit entry and counts down to 0.
- o_busy = (state != IDLE) || (level != 0).
- o_overflow is cleared only by reset.

## Timing
- Reset (asynchronous, any time, including mid-frame):
  - Outputs: o_uart_tx=1, o_cpu_clk=0, o_busy=0, o_level=0, o_overflow=0.
  - Internal: counter=0, pointers=0, FSM=IDLE, prev_tx_n=1.
  - A partially sent frame is abandoned and is not resumed.
- Push: i_data is captured on the edge that detects the falling edge of i_tx_n. o_level increments on that same edge and is visible in the following cycle.
- Latency from an empty idle state:
  - Detect edge at cycle N; FIFO non-empty visible at N+1.
  - Pop occurs at N+1 and the FSM enters START.
  - o_uart_tx goes low from cycle N+2.
- Frame length: exactly 10*CLOCKS_PER_BAUD cycles. Back-to-back frames have no gap between a stop bit and the next start bit.
- Bit k of the byte (k=0..7) occupies cycles [(1+k)*CPB, (2+k)*CPB) measured from the start of the start bit, where CPB = CLOCKS_PER_BAUD.
- o_overflow rises the cycle after the dropped push.

## Test plan
- Single byte (CLOCKS_PER_BAUD=4, DEPTH=4): pulse i_tx_n low for 20 cycles with i_data=0xA5 -> exactly one frame. Line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. o_uart_tx falls 2 cycles after the detect edge. o_level returns to 0 and o_busy drops after the stop bit.
- Burst: push 0x01, 0x02, 0x03 on consecutive edges -> o_level peaks at 2 (one byte popped immediately). Three frames are sent in order with no idle cycles between them, 120 cycles total.
- Overflow (DEPTH=4): push 6 bytes spaced 2 cycles apart during the first frame -> the first byte is on the line, the next 4 are queued, and the 6th is dropped. o_overflow=1, o_level=4, and the 5 accepted bytes are transmitted in order.
- Simultaneous push and pop at full: with the FIFO full, time a push to coincide with the STOP-to-START pop -> level stays 4 and o_overflow stays 0.
- Reset mid-frame: assert i_reset_n=0 during data bit 3 -> o_uart_tx=1 and o_level=0 immediately. After release, a new push of 0x3C transmits a clean frame.
- Divider: DIV_BIT=2 -> o_cpu_clk toggles every 4 i_clk cycles from reset. A held-low i_tx_n over 3 o_cpu_clk periods yields exactly one byte.
